// File: rtl/addsub_exec_stage.sv
// Accept/execute/hold sequencer around an external N-bit adder/subtractor.
// Optional signed saturation of the result and accumulator: define ADDSUB_SAT_EN.
module addsub_exec_stage #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_op,
   input  logic         in_clr,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic [N-1:0] as_x,
   output logic [N-1:0] as_y,
   output logic         as_cin,
   input  logic [N-1:0] as_result,
   input  logic         as_carry,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic         out_carry,
   output logic         out_zero,
   output logic         out_neg,
   output logic         out_ovf,
   output logic [N-1:0] acc
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready depends only on state; out_valid stays high and every out_*
   // field is frozen until out_ready is seen high.
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t       state;
   logic [N-1:0] yeff;
   logic         ovf;
   logic [N-1:0] fin_result;

   assign in_ready = (state == IDLE);

   // Overflow is judged on the effective Y the adder sees (inverted for subtract).
   always_comb begin
      yeff = as_y ^ {N{as_cin}};
      ovf  = (as_x[N-1] == yeff[N-1]) && (as_result[N-1] != as_x[N-1]);
   end

`ifdef ADDSUB_SAT_EN
   always_comb begin
      fin_result = as_result;
      if (ovf)
         fin_result = as_x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
   end
`else
   assign fin_result = as_result;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         as_x       <= '0;
         as_y       <= '0;
         as_cin     <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
         out_zero   <= 1'b0;
         out_neg    <= 1'b0;
         out_ovf    <= 1'b0;
         acc        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  as_y   <= in_b;
                  as_cin <= in_op[0];
                  as_x   <= in_op[1] ? (in_clr ? '0 : acc) : in_a;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               out_result <= fin_result;
               out_carry  <= as_carry;
               out_zero   <= (fin_result == '0);
               out_neg    <= fin_result[N-1];
               out_ovf    <= ovf;
               acc        <= fin_result;
               out_valid  <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_exec_stage.sv
// Directed bench for addsub_exec_stage: the driver queues hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_addsub_exec_stage;
   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_op;
   logic         in_clr;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic [N-1:0] as_x;
   logic [N-1:0] as_y;
   logic         as_cin;
   logic [N-1:0] as_result;
   logic         as_carry;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_result;
   logic         out_carry;
   logic         out_zero;
   logic         out_neg;
   logic         out_ovf;
   logic [N-1:0] acc;

   // expected entry: {result, carry, zero, neg, ovf}
   logic [N+3:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;

   addsub_exec_stage #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_clr(in_clr),
      .in_a(in_a), .in_b(in_b),
      .as_x(as_x), .as_y(as_y), .as_cin(as_cin),
      .as_result(as_result), .as_carry(as_carry),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg),
      .out_ovf(out_ovf), .acc(acc)
   );

   // External adder/subtractor: X + (Y ^ cin) + cin.
   always_comb begin
      {as_carry, as_result} = {1'b0, as_x} + {1'b0, (as_y ^ {N{as_cin}})} + {{N{1'b0}}, as_cin};
   end

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h, expected no output", out_result);
         end else begin
            logic [N+3:0] e;
            e = exp_q.pop_front();
            check("out_result", 32'(out_result), 32'(e[N+3:4]));
            check("out_carry",  32'(out_carry),  32'(e[3]));
            check("out_zero",   32'(out_zero),   32'(e[2]));
            check("out_neg",    32'(out_neg),    32'(e[1]));
            check("out_ovf",    32'(out_ovf),    32'(e[0]));
            check("acc",        32'(acc),        32'(e[N+3:4]));
         end
      end
   end

   // driver: issue one command, check operand latching and result latency
   task automatic send(input logic [1:0] op, input logic clr, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] exp_x,
                       input logic [N+3:0] exp);
      int n;
      in_valid = 1'b1;
      in_op    = op;
      in_clr   = clr;
      in_a     = a;
      in_b     = b;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1");
      end
      exp_q.push_back(exp);
      tick();
      in_valid = 1'b0;
      check("as_x",   32'(as_x),   32'(exp_x));
      check("as_y",   32'(as_y),   32'(b));
      check("as_cin", 32'(as_cin), 32'(op[0]));
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (n < 1 || n > 2) begin
         errors++;
         $display("FAIL latency: got %0d edges, expected 1..2", n);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_clr    = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("rst_in_ready",   32'(in_ready),   32'd1);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_acc",        32'(acc),        32'd0);
      check("rst_as_x",       32'(as_x),       32'd0);
      check("rst_as_y",       32'(as_y),       32'd0);
      check("rst_as_cin",     32'(as_cin),     32'd0);
      rst_n = 1'b1;
      tick();

      send(2'b00, 1'b0, 8'h05, 8'h03, 8'h05, {8'h08, 4'b0000});
      send(2'b01, 1'b0, 8'h03, 8'h05, 8'h03, {8'hFE, 4'b0010});
      send(2'b01, 1'b0, 8'h05, 8'h05, 8'h05, {8'h00, 4'b1100});
`ifdef ADDSUB_SAT_EN
      send(2'b00, 1'b0, 8'h7F, 8'h01, 8'h7F, {8'h7F, 4'b0001});
      send(2'b01, 1'b0, 8'h80, 8'h01, 8'h80, {8'h80, 4'b1011});
`else
      send(2'b00, 1'b0, 8'h7F, 8'h01, 8'h7F, {8'h80, 4'b0011});
      send(2'b01, 1'b0, 8'h80, 8'h01, 8'h80, {8'h7F, 4'b1001});
`endif
      // accumulator chain; in_a carries junk to show it is ignored
      send(2'b10, 1'b1, 8'hAA, 8'h10, 8'h00, {8'h10, 4'b0000});
      send(2'b10, 1'b0, 8'h55, 8'h20, 8'h10, {8'h30, 4'b0000});
      send(2'b11, 1'b0, 8'hAA, 8'h40, 8'h30, {8'hF0, 4'b0010});
      send(2'b11, 1'b1, 8'h00, 8'h01, 8'h00, {8'hFF, 4'b0010});

      // backpressure with a second command waiting
      tick();
      out_ready = 1'b0;
      send(2'b00, 1'b0, 8'h11, 8'h22, 8'h11, {8'h33, 4'b0000});
      in_valid = 1'b1;
      in_op    = 2'b10;
      in_clr   = 1'b0;
      in_a     = 8'hEE;
      in_b     = 8'h01;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_in_ready",   32'(in_ready),   32'd0);
         check("bp_out_valid",  32'(out_valid),  32'd1);
         check("bp_out_result", 32'(out_result), 32'h33);
         check("bp_acc",        32'(acc),        32'h33);
         check("bp_as_x",       32'(as_x),       32'h11);
      end
      out_ready = 1'b1;
      exp_q.push_back({8'h34, 4'b0000});
      tick();
      check("bp_exit_in_ready",  32'(in_ready),  32'd1);
      check("bp_exit_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      check("bp_accept_in_ready", 32'(in_ready), 32'd0);
      check("bp_accept_as_x",     32'(as_x),     32'h33);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 10) begin
            tick();
            n++;
         end
         checks++;
         if (n >= 10) begin
            errors++;
            $display("FAIL bp_second_timeout: got out_valid=0, expected 1");
         end
      end
      tick();

      // reset asserted while a command is in EXEC
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = 8'h40;
      in_b     = 8'h40;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_acc",       32'(acc),       32'd0);
      check("arst_in_ready",  32'(in_ready),  32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      send(2'b00, 1'b0, 8'h05, 8'h03, 8'h05, {8'h08, 4'b0000});

      repeat (4) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
